// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode pipeline boundary: skid-buffer
// states, the MIPS NOP encoding and the default field widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    localparam logic [31:0] MIPS_NOP       = 32'h0000_0000;
    localparam int          PIPE_ADDR_W    = 32;
    localparam int          PIPE_INSTR_W   = 32;
    localparam int          PIPE_CNT_W     = 16;

    // True when a state can still take a new instruction from fetch.
    function automatic logic can_accept(input skid_state_e st);
        return st != FULL;
    endfunction

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (inc && (cnt_reg != {W{1'b1}})) begin
            cnt_next = cnt_reg + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;

endmodule : sat_counter

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer and registered in_ready.
// Optional stall/flush performance counters are enabled by IF_ID_PERF_CNT_EN.
module if_id_skid_reg
    import pipe_pkg::*;
#(
    parameter int                 ADDR_W    = PIPE_ADDR_W,
    parameter int                 INSTR_W   = PIPE_INSTR_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(MIPS_NOP)
`ifdef IF_ID_PERF_CNT_EN
    ,
    parameter int                 CNT_W     = PIPE_CNT_W
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  in_pc_plus4,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc_plus4,
    output logic [INSTR_W-1:0] out_instr
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
`endif
);

    skid_state_e        state_reg;
    skid_state_e        state_next;

    logic [ADDR_W-1:0]  main_pc_reg;
    logic [ADDR_W-1:0]  main_pc_next;
    logic [INSTR_W-1:0] main_instr_reg;
    logic [INSTR_W-1:0] main_instr_next;
    logic [ADDR_W-1:0]  skid_pc_reg;
    logic [ADDR_W-1:0]  skid_pc_next;
    logic [INSTR_W-1:0] skid_instr_reg;
    logic [INSTR_W-1:0] skid_instr_next;

    logic acc;
    logic fire;

    // Handshake outputs depend on the state flops only.
    assign out_valid = (state_reg != EMPTY);
    assign in_ready  = can_accept(state_reg);

    assign acc  = in_valid & in_ready;
    assign fire = out_valid & out_ready;

    always_comb begin
        state_next      = state_reg;
        main_pc_next    = main_pc_reg;
        main_instr_next = main_instr_reg;
        skid_pc_next    = skid_pc_reg;
        skid_instr_next = skid_instr_reg;

        case (state_reg)
            EMPTY: begin
                if (acc) begin
                    state_next      = ONE;
                    main_pc_next    = in_pc_plus4;
                    main_instr_next = in_instr;
                end
            end
            ONE: begin
                if (acc && fire) begin
                    main_pc_next    = in_pc_plus4;
                    main_instr_next = in_instr;
                end else if (acc) begin
                    // Decode stalled: park the new instruction behind main.
                    state_next      = FULL;
                    skid_pc_next    = in_pc_plus4;
                    skid_instr_next = in_instr;
                end else if (fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (fire) begin
                    state_next      = ONE;
                    main_pc_next    = skid_pc_reg;
                    main_instr_next = skid_instr_reg;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase

        // Flush kills both entries and any instruction accepted this cycle.
        if (flush) begin
            state_next      = EMPTY;
            main_pc_next    = '0;
            main_instr_next = NOP_INSTR;
            skid_pc_next    = '0;
            skid_instr_next = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= EMPTY;
            main_pc_reg    <= '0;
            main_instr_reg <= NOP_INSTR;
            skid_pc_reg    <= '0;
            skid_instr_reg <= NOP_INSTR;
        end else begin
            state_reg      <= state_next;
            main_pc_reg    <= main_pc_next;
            main_instr_reg <= main_instr_next;
            skid_pc_reg    <= skid_pc_next;
            skid_instr_reg <= skid_instr_next;
        end
    end

    assign out_pc_plus4 = main_pc_reg;
    assign out_instr    = main_instr_reg;

`ifdef IF_ID_PERF_CNT_EN
    // Slot 0 counts stalled cycles, slot 1 counts flush cycles.
    logic [1:0]       perf_inc;
    logic [CNT_W-1:0] perf_cnt [2];

    assign perf_inc = {flush, out_valid & ~out_ready};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            sat_counter #(
                .W(CNT_W)
            ) u_cnt (
                .clk  (clk),
                .rst_n(rst_n),
                .inc  (perf_inc[gi]),
                .cnt  (perf_cnt[gi])
            );
        end
    endgenerate

    assign stall_cnt = perf_cnt[0];
    assign flush_cnt = perf_cnt[1];
`endif

endmodule : if_id_skid_reg

// File: tb/tb_if_id_skid_reg.sv
// Directed, table-driven bench for if_id_skid_reg; counter checks run only
// when IF_ID_PERF_CNT_EN is defined.
module tb_if_id_skid_reg;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc_plus4;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_instr;

    int n_tests;
    int n_fail;

`ifdef IF_ID_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_pc_plus4;
    logic [31:0] s_out_instr;
    logic [2:0]  s_stall_cnt;
    logic [2:0]  s_flush_cnt;
`endif

    if_id_skid_reg #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .NOP_INSTR(NOP)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .CNT_W    (16)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc_plus4 (in_pc_plus4),
        .in_instr    (in_instr),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc_plus4(out_pc_plus4),
        .out_instr   (out_instr)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

`ifdef IF_ID_PERF_CNT_EN
    if_id_skid_reg #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .NOP_INSTR(NOP),
        .CNT_W    (3)
    ) dut_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (s_in_ready),
        .in_pc_plus4 (in_pc_plus4),
        .in_instr    (in_instr),
        .flush       (flush),
        .out_valid   (s_out_valid),
        .out_ready   (out_ready),
        .out_pc_plus4(s_out_pc_plus4),
        .out_instr   (s_out_instr),
        .stall_cnt   (s_stall_cnt),
        .flush_cnt   (s_flush_cnt)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        fl;
        logic        ordy;
        logic        eov;
        logic        eir;
        logic        chk;
        logic [31:0] epc;
        logic [31:0] eins;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                                input logic fl, input logic ordy, input logic eov, input logic eir,
                                input logic chk, input logic [31:0] epc, input logic [31:0] eins);
        vec_t v;
        v.iv = iv; v.pc = pc; v.ins = ins; v.fl = fl; v.ordy = ordy;
        v.eov = eov; v.eir = eir; v.chk = chk; v.epc = epc; v.eins = eins;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic fl, input logic ordy);
        in_valid    = iv;
        in_pc_plus4 = pc;
        in_instr    = ins;
        flush       = fl;
        out_ready   = ordy;
    endtask

    // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge.
    task automatic cycle(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic fl, input logic ordy);
        drive(iv, pc, ins, fl, ordy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Columns: in_valid, pc4, instr, flush, out_ready | out_valid, in_ready, chk, pc4, instr
        // Streaming with decode always ready
        vecs[0]  = mk(1, 32'h4,  32'h2008_0005, 0, 1,  1, 1, 1, 32'h4,  32'h2008_0005);
        vecs[1]  = mk(1, 32'h8,  32'h2009_0003, 0, 1,  1, 1, 1, 32'h8,  32'h2009_0003);
        vecs[2]  = mk(1, 32'hC,  32'h0109_5020, 0, 1,  1, 1, 1, 32'hC,  32'h0109_5020);
        vecs[3]  = mk(1, 32'h10, 32'hAC0A_0000, 0, 1,  1, 1, 1, 32'h10, 32'hAC0A_0000);
        vecs[4]  = mk(0, 32'h0,  32'h0,         0, 1,  0, 1, 0, 32'h0,  32'h0);
        // Stall fills skid, in_ready drops, head stays stable, then drains in order
        vecs[5]  = mk(1, 32'h4,  32'h2008_0005, 0, 0,  1, 1, 1, 32'h4,  32'h2008_0005);
        vecs[6]  = mk(1, 32'h8,  32'h2009_0003, 0, 0,  1, 0, 1, 32'h4,  32'h2008_0005);
        vecs[7]  = mk(1, 32'hC,  32'h0109_5020, 0, 0,  1, 0, 1, 32'h4,  32'h2008_0005);
        vecs[8]  = mk(1, 32'hC,  32'h0109_5020, 0, 1,  1, 1, 1, 32'h8,  32'h2009_0003);
        vecs[9]  = mk(1, 32'hC,  32'h0109_5020, 0, 1,  1, 1, 1, 32'hC,  32'h0109_5020);
        vecs[10] = mk(0, 32'h0,  32'h0,         0, 1,  0, 1, 0, 32'h0,  32'h0);
        // Flush while FULL, then the next accepted instruction is the first output
        vecs[11] = mk(1, 32'h14, 32'h1111_1111, 0, 0,  1, 1, 1, 32'h14, 32'h1111_1111);
        vecs[12] = mk(1, 32'h18, 32'h2222_2222, 0, 0,  1, 0, 1, 32'h14, 32'h1111_1111);
        vecs[13] = mk(1, 32'h1C, 32'h3333_3333, 1, 0,  0, 1, 1, 32'h0,  NOP);
        vecs[14] = mk(1, 32'h40, 32'h4444_4444, 0, 0,  1, 1, 1, 32'h40, 32'h4444_4444);
        vecs[15] = mk(0, 32'h0,  32'h0,         0, 1,  0, 1, 0, 32'h0,  32'h0);
        // Flush and accept in the same cycle while EMPTY: input dropped
        vecs[16] = mk(1, 32'h44, 32'h5555_5555, 1, 1,  0, 1, 1, 32'h0,  NOP);
        vecs[17] = mk(0, 32'h0,  32'h0,         0, 1,  0, 1, 1, 32'h0,  NOP);
        // Flush in ONE while a transfer would otherwise replace main
        vecs[18] = mk(1, 32'h48, 32'h6666_6666, 0, 1,  1, 1, 1, 32'h48, 32'h6666_6666);
        vecs[19] = mk(1, 32'h4C, 32'h7777_7777, 1, 1,  0, 1, 1, 32'h0,  NOP);

        // Reset: two cycles low, then release
        rst_n = 1'b0;
        drive(0, 32'h0, 32'h0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset in_ready",  {31'b0, in_ready},  32'd1);
        check("reset out_instr", out_instr,          NOP);
        check("reset out_pc4",   out_pc_plus4,       32'h0);
        $display("[TB] reset: out_valid=%0b in_ready=%0b pc4=%h instr=%h",
                 out_valid, in_ready, out_pc_plus4, out_instr);

        for (int i = 0; i < NVEC; i++) begin
            cycle(vecs[i].iv, vecs[i].pc, vecs[i].ins, vecs[i].fl, vecs[i].ordy);
            check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].eov});
            check($sformatf("vec%0d in_ready", i),  {31'b0, in_ready},  {31'b0, vecs[i].eir});
            if (vecs[i].chk) begin
                check($sformatf("vec%0d out_pc4", i),   out_pc_plus4, vecs[i].epc);
                check($sformatf("vec%0d out_instr", i), out_instr,    vecs[i].eins);
            end
            $display("[TB] vec %0d: iv=%0b pc4=%h fl=%0b ordy=%0b -> ov=%0b ir=%0b pc4=%h instr=%h",
                     i, vecs[i].iv, vecs[i].pc, vecs[i].fl, vecs[i].ordy,
                     out_valid, in_ready, out_pc_plus4, out_instr);
        end

        // Reset mid-stall (with a simultaneous flush) discards both entries
        cycle(1, 32'h60, 32'hAAAA_0001, 0, 0);
        cycle(1, 32'h64, 32'hAAAA_0002, 0, 0);
        check("midstall full in_ready", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0;
        cycle(0, 32'h0, 32'h0, 1, 0);
        check("midrst out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst in_ready",  {31'b0, in_ready},  32'd1);
        check("midrst out_pc4",   out_pc_plus4,       32'h0);
        check("midrst out_instr", out_instr,          NOP);
        $display("[TB] reset mid-stall: ov=%0b ir=%0b pc4=%h", out_valid, in_ready, out_pc_plus4);
        rst_n = 1'b1;
        cycle(1, 32'h50, 32'hBBBB_0000, 0, 0);
        check("postrst out_pc4",   out_pc_plus4,       32'h50);
        check("postrst out_valid", {31'b0, out_valid}, 32'd1);
        cycle(0, 32'h0, 32'h0, 0, 1);
        check("postrst drained", {31'b0, out_valid}, 32'd0);
        $display("[TB] post-reset transfer: pc4=50 delivered, ov=%0b", out_valid);

`ifdef IF_ID_PERF_CNT_EN
        // 5 stalled cycles and 2 flush cycles since the reset above
        cycle(1, 32'h70, 32'hCCCC_0000, 0, 0);
        for (int k = 0; k < 5; k++) cycle(0, 32'h0, 32'h0, 0, 0);
        cycle(0, 32'h0, 32'h0, 1, 1);
        cycle(0, 32'h0, 32'h0, 1, 1);
        check("stall_cnt 5",       {16'b0, stall_cnt},   32'd5);
        check("flush_cnt 2",       {16'b0, flush_cnt},   32'd2);
        check("small stall_cnt 5", {29'b0, s_stall_cnt}, 32'd5);
        check("small flush_cnt 2", {29'b0, s_flush_cnt}, 32'd2);
        $display("[TB] perf: stall=%0d flush=%0d small_stall=%0d", stall_cnt, flush_cnt, s_stall_cnt);
        // 10 more stall cycles saturate the 3-bit counter at 7
        cycle(1, 32'h74, 32'hCCCC_0001, 0, 0);
        for (int k = 0; k < 10; k++) cycle(0, 32'h0, 32'h0, 0, 0);
        check("stall_cnt 15",      {16'b0, stall_cnt},   32'd15);
        check("small stall sat 7", {29'b0, s_stall_cnt}, 32'd7);
        check("flush_cnt hold 2",  {16'b0, flush_cnt},   32'd2);
        $display("[TB] perf sat: stall=%0d small_stall=%0d", stall_cnt, s_stall_cnt);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_if_id_skid_reg

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- Parametrised IF/ID pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Sits between fetch (PC/IMEM) and decode. Supports decode backpressure (stall) and branch/jump flush without dropping or duplicating fetched instructions.
- `in_ready` is fully registered, so the stall path never combinationally reaches fetch.

Parameters:
- `ADDR_W`, 32, width of the PC+4 field.
- `INSTR_W`, 32, width of the instruction field.
- `NOP_INSTR`, 32'h0000_0000, encoding loaded into the instruction field on reset or flush (MIPS `sll $0,$0,0`).
- `CNT_W`, 16, width of the perf counters (used only with `IF_ID_PERF_CNT_EN`).

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous reset, active-low.
- `in_valid` in 1: fetch presents a valid instruction.
- `in_ready` out 1: stage can accept; registered.
- `in_pc_plus4` in `ADDR_W`: PC+4 of the fetched instruction.
- `in_instr` in `INSTR_W`: fetched instruction.
- `flush` in 1: kill all held and incoming instructions.
- `out_valid` out 1: decode-side data valid.
- `out_ready` in 1: decode accepts (deasserted = stall).
- `out_pc_plus4` out `ADDR_W`: registered PC+4.
- `out_instr` out `INSTR_W`: registered instruction.

Behaviour:
- **Transfers.** `acc = in_valid & in_ready`; `fire = out_valid & out_ready`.
- **Storage.** Main entry (drives outputs) plus skid entry. States: EMPTY, ONE, FULL.
- **Output mapping.** `out_valid = (state != EMPTY)`; `in_ready = (state != FULL)`. Both come straight from flops/state.
- **EMPTY:**
  - `acc` -> ONE, main <= in.
- **ONE:**
  - `acc & !fire` -> FULL, skid <= in.
  - `fire & !acc` -> EMPTY.
  - `acc & fire` -> ONE, main <= in.
  - neither -> hold.
- **FULL:**
  - `fire` -> ONE, main <= skid.
  - else hold.
  - `acc` is impossible in FULL (`in_ready` = 0).
- **Latency.** 1 cycle from `acc` to `out_valid` when empty. Throughput is 1/cycle with `out_ready` held high.
- **Ordering.** Strict FIFO order; no loss and no duplication.
- **Output stability.** While `out_valid & !out_ready`, `out_pc_plus4` and `out_instr` are stable.
- **Flush:**
  - Synchronous; overrides all transitions. Next state EMPTY, and any same-cycle `acc` is discarded.
  - Main/skid are loaded with pc = 0, instr = `NOP_INSTR`.
  - `in_ready` = 1 the following cycle.
  - `flush` while EMPTY has the same result.
- **Reset (`rst_n` = 0 at clk edge):**
  - state EMPTY, `out_valid` = 0, `in_ready` = 1.
  - `out_pc_plus4` = 0, `out_instr` = `NOP_INSTR`, skid cleared.
  - Reset beats flush. Reset mid-stall discards both entries.
- **After fire to EMPTY (no flush).** Data outputs hold their last value; they are don't-care while `out_valid` = 0.
- **Widths.** No arithmetic on the data path; fields are copied bit-exact.

Optional Feature:
- Macro: `IF_ID_PERF_CNT_EN`.
- **Defined:** adds outputs `stall_cnt` (`CNT_W`) and `flush_cnt` (`CNT_W`).
  - `stall_cnt` +1 on each cycle with `out_valid & !out_ready`.
  - `flush_cnt` +1 on each cycle with `flush` = 1.
  - Both saturate at all-ones. Both reset to 0 on `rst_n`; `flush` does not clear them.
- **Undefined:** ports and logic are absent; handshake behaviour is identical.

Decomposition:
- **Package `pipe_pkg`:** state enum (EMPTY/ONE/FULL), `MIPS_NOP` constant (32'h0), default widths.
- **Sub-module `sat_counter`** (params `W`; ports `clk`, `rst_n`, `inc`, `cnt`). Instantiated twice under `IF_ID_PERF_CNT_EN`. No other sub-modules.

Test Plan:
- **Reset:** `rst_n`=0 for 2 cycles, then 1 -> `out_valid`=0, `in_ready`=1, `out_instr`=0, `out_pc_plus4`=0.
- **Streaming:** `out_ready`=1, `in_valid`=1 for 4 cycles with (pc4, instr) = (0x4, 0x20080005), (0x8, 0x20090003), (0xC, 0x01095020), (0x10, 0xAC0A0000).
  - Outputs appear 1 cycle later in order, `out_valid` high 4 cycles.
  - `in_ready` never drops.
- **Stall / skid:** `out_ready`=0 while sending 0x4, 0x8, 0xC.
  - `in_ready` falls after 2 accepts; 0xC is held off; 0x4 is stable on the outputs.
  - Release `out_ready` -> 0x4, 0x8, 0xC delivered in order with no duplicate.
- **Flush while FULL:** `flush`=1 -> next cycle `out_valid`=0, `out_instr`=`NOP_INSTR`, `in_ready`=1.
  - The next accepted instr (pc4 0x40) is the first output.
- **Flush and accept in the same cycle:** the input is dropped and `out_valid` stays 0.
- **Perf counters (`IF_ID_PERF_CNT_EN` defined):** 5 stall cycles and 2 flushes -> `stall_cnt`=5, `flush_cnt`=2.
  - With `CNT_W`=3 and 10 stall cycles, `stall_cnt` saturates at 7.
